// File: rtl/alu_op_sequencer.sv
// Decodes ARM data-processing ops into an ALU control word, holding it in a
// single-entry buffer. Multiplies spend MUL_CYCLES busy cycles before the word is valid.
module alu_op_sequencer #(
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_in_valid,
    output logic       o_in_ready,
    input  logic [3:0] i_cmd,
    input  logic       i_s_bit,
    input  logic       i_mul,
    input  logic       i_flush,
    output logic       o_out_valid,
    input  logic       i_out_ready,
    output logic [3:0] o_sel,
    output logic       o_swap_ops,
    output logic       o_use_carry,
    output logic       o_reg_write,
    output logic [1:0] o_flag_wr,
    output logic       o_busy
);

    typedef enum logic [1:0] {StIdle, StMulw, StValid} state_t;

    localparam logic [3:0] MulLoad = 4'(MUL_CYCLES - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [3:0] r_sel;
    logic       r_swap_ops;
    logic       r_use_carry;
    logic       r_reg_write;
    logic [1:0] r_flag_wr;

    logic [3:0] w_sel;
    logic       w_swap_ops;
    logic       w_use_carry;
    logic       w_reg_write;
    logic       w_test;
    logic [1:0] w_flag_wr;

    always_comb begin
        w_sel       = 4'd0;
        w_swap_ops  = 1'b0;
        w_use_carry = 1'b0;
        w_reg_write = 1'b1;
        w_test      = 1'b0;
        if (i_mul) begin
            w_sel = 4'd8;
        end else begin
            unique case (i_cmd)
                4'b0000: w_sel = 4'd2;
                4'b0001: w_sel = 4'd4;
                4'b0010: w_sel = 4'd1;
                4'b0011: begin w_sel = 4'd1; w_swap_ops = 1'b1; end
                4'b0100: w_sel = 4'd0;
                4'b0101: begin w_sel = 4'd0; w_use_carry = 1'b1; end
                4'b0110: begin w_sel = 4'd1; w_use_carry = 1'b1; end
                4'b0111: begin w_sel = 4'd1; w_swap_ops = 1'b1; w_use_carry = 1'b1; end
                4'b1000: begin w_sel = 4'd2; w_reg_write = 1'b0; w_test = 1'b1; end
                4'b1001: begin w_sel = 4'd4; w_reg_write = 1'b0; w_test = 1'b1; end
                4'b1010: begin w_sel = 4'd1; w_reg_write = 1'b0; w_test = 1'b1; end
                4'b1011: begin w_sel = 4'd0; w_reg_write = 1'b0; w_test = 1'b1; end
                4'b1100: w_sel = 4'd3;
                4'b1101: w_sel = 4'd5;
                4'b1110: w_sel = 4'd6;
                4'b1111: w_sel = 4'd7;
                default: w_sel = 4'd0;
            endcase
        end
        w_flag_wr[1] = i_s_bit | w_test;
        // Carry/overflow only make sense for the adder paths.
        w_flag_wr[0] = w_flag_wr[1] & ((w_sel == 4'd0) | (w_sel == 4'd1));
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_cnt       <= 4'd0;
            r_sel       <= 4'd0;
            r_swap_ops  <= 1'b0;
            r_use_carry <= 1'b0;
            r_reg_write <= 1'b0;
            r_flag_wr   <= 2'b00;
        end else if (i_flush) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_in_valid) begin
                        r_sel       <= w_sel;
                        r_swap_ops  <= w_swap_ops;
                        r_use_carry <= w_use_carry;
                        r_reg_write <= w_reg_write;
                        r_flag_wr   <= w_flag_wr;
                        if (i_mul) begin
                            r_state <= StMulw;
                            r_cnt   <= MulLoad;
                        end else begin
                            r_state <= StValid;
                        end
                    end
                end
                StMulw: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= StValid;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                StValid: begin
                    if (i_out_ready) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // in_ready is gated so it reads 0 while reset is held, yet 1 at the first edge after.
    assign o_in_ready  = (r_state == StIdle) & ~i_reset;
    assign o_out_valid = (r_state == StValid);
    assign o_busy      = (r_state != StIdle);
    assign o_sel       = r_sel;
    assign o_swap_ops  = r_swap_ops;
    assign o_use_carry = r_use_carry;
    assign o_reg_write = r_reg_write;
    assign o_flag_wr   = r_flag_wr;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: decode table sweep plus multi-cycle
// multiply, stall, flush and asynchronous reset sequences.
module tb_alu_op_sequencer;

    localparam int unsigned MulCycles = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] cmd;
    logic       s_bit;
    logic       mul;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] sel;
    logic       swap_ops;
    logic       use_carry;
    logic       reg_write;
    logic [1:0] flag_wr;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    alu_op_sequencer #(
        .MUL_CYCLES(MulCycles)
    ) u_dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .i_cmd      (cmd),
        .i_s_bit    (s_bit),
        .i_mul      (mul),
        .i_flush    (flush),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready),
        .o_sel      (sel),
        .o_swap_ops (swap_ops),
        .o_use_carry(use_carry),
        .o_reg_write(reg_write),
        .o_flag_wr  (flag_wr),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cmd;
        logic       s_bit;
        logic       mul;
        logic [3:0] sel;
        logic       swap;
        logic       carry;
        logic       rw;
        logic [1:0] fw;
    } vec_t;

    vec_t vecs[34];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_vecs();
        // {cmd, s, mul, sel, swap, carry, rw, flag_wr}
        vecs[0]  = '{4'b0000, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 2'b00};
        vecs[1]  = '{4'b0000, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 2'b10};
        vecs[2]  = '{4'b0001, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 1'b1, 2'b00};
        vecs[3]  = '{4'b0001, 1'b1, 1'b0, 4'd4, 1'b0, 1'b0, 1'b1, 2'b10};
        vecs[4]  = '{4'b0010, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 2'b00};
        vecs[5]  = '{4'b0010, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 2'b11};
        vecs[6]  = '{4'b0011, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b1, 2'b00};
        vecs[7]  = '{4'b0011, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b1, 2'b11};
        vecs[8]  = '{4'b0100, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 2'b00};
        vecs[9]  = '{4'b0100, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 2'b11};
        vecs[10] = '{4'b0101, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 2'b00};
        vecs[11] = '{4'b0101, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 2'b11};
        vecs[12] = '{4'b0110, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1, 1'b1, 2'b00};
        vecs[13] = '{4'b0110, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 1'b1, 2'b11};
        vecs[14] = '{4'b0111, 1'b0, 1'b0, 4'd1, 1'b1, 1'b1, 1'b1, 2'b00};
        vecs[15] = '{4'b0111, 1'b1, 1'b0, 4'd1, 1'b1, 1'b1, 1'b1, 2'b11};
        vecs[16] = '{4'b1000, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 2'b10};
        vecs[17] = '{4'b1000, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 2'b10};
        vecs[18] = '{4'b1001, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, 2'b10};
        vecs[19] = '{4'b1001, 1'b1, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, 2'b10};
        vecs[20] = '{4'b1010, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 2'b11};
        vecs[21] = '{4'b1010, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 2'b11};
        vecs[22] = '{4'b1011, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b11};
        vecs[23] = '{4'b1011, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b11};
        vecs[24] = '{4'b1100, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b1, 2'b00};
        vecs[25] = '{4'b1100, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b1, 2'b10};
        vecs[26] = '{4'b1101, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1, 2'b00};
        vecs[27] = '{4'b1101, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1, 2'b10};
        vecs[28] = '{4'b1110, 1'b0, 1'b0, 4'd6, 1'b0, 1'b0, 1'b1, 2'b00};
        vecs[29] = '{4'b1110, 1'b1, 1'b0, 4'd6, 1'b0, 1'b0, 1'b1, 2'b10};
        vecs[30] = '{4'b1111, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1, 2'b00};
        vecs[31] = '{4'b1111, 1'b1, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1, 2'b10};
        // Multiply overrides cmd, even a compare opcode.
        vecs[32] = '{4'b1010, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b1, 2'b00};
        vecs[33] = '{4'b0011, 1'b1, 1'b1, 4'd8, 1'b0, 1'b0, 1'b1, 2'b10};
    endtask

    task automatic check_word(input string nm, input logic [3:0] e_sel, input logic e_swap,
                              input logic e_carry, input logic e_rw, input logic [1:0] e_fw);
        chk({nm, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_sel"}, 32'(sel), 32'(e_sel));
        chk({nm, "_swap"}, 32'(swap_ops), 32'(e_swap));
        chk({nm, "_carry"}, 32'(use_carry), 32'(e_carry));
        chk({nm, "_reg_write"}, 32'(reg_write), 32'(e_rw));
        chk({nm, "_flag_wr"}, 32'(flag_wr), 32'(e_fw));
    endtask

    initial begin
        int n;
        fill_vecs();
        reset     = 1'b1;
        in_valid  = 1'b0;
        cmd       = 4'd0;
        s_bit     = 1'b0;
        mul       = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset state, with an operation already offered.
        #2;
        in_valid = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_flag_wr", 32'(flag_wr), 32'd0);
        tick();
        chk("rst_held_busy", 32'(busy), 32'd0);

        // RSB with S, accepted on the first edge after reset release.
        cmd = 4'b0011; s_bit = 1'b1; out_ready = 1'b1;
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check_word("rsb", 4'd1, 1'b1, 1'b0, 1'b1, 2'b11);
        chk("rsb_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("rsb_done_valid", 32'(out_valid), 32'd0);
        chk("rsb_done_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        // Table sweep.
        for (int i = 0; i < 34; i++) begin
            in_valid = 1'b1;
            cmd = vecs[i].cmd; s_bit = vecs[i].s_bit; mul = vecs[i].mul;
            tick();
            in_valid = 1'b0; mul = 1'b0;
            n = 0;
            while (!out_valid && n < 20) begin
                tick();
                n++;
            end
            if (vecs[i].mul) chk($sformatf("vec%0d_mul_wait", i), 32'(n), 32'(MulCycles));
            check_word($sformatf("vec%0d", i), vecs[i].sel, vecs[i].swap, vecs[i].carry,
                       vecs[i].rw, vecs[i].fw);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk($sformatf("vec%0d_idle", i), 32'(in_ready), 32'd1);
        end

        // Multiply timing: busy with out_valid low for exactly MulCycles cycles.
        in_valid = 1'b1; mul = 1'b1; cmd = 4'b0100; s_bit = 1'b0; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; mul = 1'b0;
        for (int k = 0; k < int'(MulCycles); k++) begin
            chk($sformatf("mulw%0d_busy", k), 32'(busy), 32'd1);
            chk($sformatf("mulw%0d_out_valid", k), 32'(out_valid), 32'd0);
            chk($sformatf("mulw%0d_in_ready", k), 32'(in_ready), 32'd0);
            tick();
        end
        check_word("mul", 4'd8, 1'b0, 1'b0, 1'b1, 2'b00);
        tick();
        chk("mul_done_busy", 32'(busy), 32'd0);
        out_ready = 1'b0;

        // CMP stalled by out_ready=0; a competing op must not overwrite the word.
        in_valid = 1'b1; cmd = 4'b1010; s_bit = 1'b0;
        tick();
        cmd = 4'b1101; s_bit = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check_word($sformatf("stall%0d", k), 4'd1, 1'b0, 1'b0, 1'b0, 2'b11);
            chk($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("stall_release_valid", 32'(out_valid), 32'd0);
        chk("stall_release_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        // Flush in MULW cycle 2 beats a simultaneous accept.
        in_valid = 1'b1; mul = 1'b1; cmd = 4'b0000; s_bit = 1'b0;
        tick();
        in_valid = 1'b0; mul = 1'b0;
        tick();
        flush = 1'b1; in_valid = 1'b1; cmd = 4'b1101;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_mulw_busy", 32'(busy), 32'd0);
        chk("flush_mulw_ready", 32'(in_ready), 32'd1);
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (out_valid) n++;
            tick();
        end
        chk("flush_mulw_no_valid", 32'(n), 32'd0);

        // Flush in VALID beats consumption and acceptance.
        in_valid = 1'b1; cmd = 4'b0100;
        tick();
        chk("pre_flush_valid", 32'(out_valid), 32'd1);
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        chk("flush_valid_out_valid", 32'(out_valid), 32'd0);
        chk("flush_valid_busy", 32'(busy), 32'd0);
        tick();
        chk("flush_valid_still_idle", 32'(out_valid), 32'd0);

        // Asynchronous reset in VALID, mid-cycle.
        in_valid = 1'b1; cmd = 4'b0001; s_bit = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("pre_areset_valid", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_out_valid", 32'(out_valid), 32'd0);
        chk("areset_busy", 32'(busy), 32'd0);
        chk("areset_in_ready", 32'(in_ready), 32'd0);
        chk("areset_sel", 32'(sel), 32'd0);
        #1;
        reset = 1'b0;
        #1;
        chk("areset_release_ready", 32'(in_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule
